// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set generator feeding the 8b10b encoder; optional PCS_TX_CARRIER_EXT_EN adds carrier extension (EXT).
// Latency: one cycle from GMII sample to registered enc_* outputs.
// Backpressure: none; one code-group is emitted every tx_clk cycle.
module pcs_tx_ordered_set #(
  parameter logic RD_INIT = 1'b0,
  parameter int   V_ON_ER = 1
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_er,
  input  logic [1:0]  xmit,
  input  logic [15:0] cfg_word,
  input  logic        enc_rd_next,
  output logic [7:0]  enc_data,
  output logic [3:0]  enc_sel,
  output logic        enc_rd,
  output logic        tx_even,
  output logic        transmitting
);

  localparam logic [3:0] SEL_DATA = 4'b1101;
  localparam logic [3:0] SEL_K285 = 4'b1100;
  localparam logic [3:0] SEL_S    = 4'b1000;
  localparam logic [3:0] SEL_T    = 4'b1001;
  localparam logic [3:0] SEL_R    = 4'b1011;
  localparam logic [3:0] SEL_V    = 4'b1010;
  localparam logic [3:0] SEL_D215 = 4'b1110;
  localparam logic [3:0] SEL_D22  = 4'b1111;
  localparam logic [3:0] SEL_D56  = 4'b0000;
  localparam logic [3:0] SEL_D162 = 4'b0001;

  localparam logic [1:0] XMIT_CONFIG = 2'b01;
  localparam logic [1:0] XMIT_DATA   = 2'b10;

  typedef enum logic [2:0] {
    IDLE, CFG, START, DATA, END_T, END_R1, END_R2
`ifdef PCS_TX_CARRIER_EXT_EN
    , EXT
`endif
  } state_t;

  state_t      state, nextState;
  logic [2:0]  cfgPos, nextCfgPos;
  logic [15:0] cfgReg, nextCfgReg;
  logic [3:0]  nextSel;
  logic [7:0]  nextData;
  logic        nextTx;

`ifdef PCS_TX_CARRIER_EXT_EN
  logic extCond;
  assign extCond = !gmii_tx_en && gmii_tx_er && (gmii_txd == 8'h0F);
`endif

  always_comb begin
    nextState  = state;
    nextSel    = SEL_K285;
    nextData   = 8'h00;
    nextCfgPos = cfgPos + 3'd1;
    nextCfgReg = cfgReg;

    case (state)
      IDLE: begin
        if (!tx_even) begin
          if (xmit == XMIT_CONFIG) begin
            nextState  = CFG;
            nextCfgPos = 3'd0;
            nextCfgReg = cfg_word;
          end else if (xmit == XMIT_DATA && gmii_tx_en) begin
            nextState = START;
            nextSel   = SEL_S;
          end
        end else begin
          // enc_rd_next is the disparity that will accompany the odd idle symbol
          nextSel = enc_rd_next ? SEL_D162 : SEL_D56;
        end
      end

      CFG: begin
        if (cfgPos[1:0] == 2'd3) begin
          if (xmit == XMIT_CONFIG) begin
            nextCfgReg = cfg_word;
          end else begin
            nextState = IDLE;
          end
        end else begin
          case (nextCfgPos[1:0])
            2'd1: nextSel = nextCfgPos[2] ? SEL_D22 : SEL_D215;
            2'd2: begin
              nextSel  = SEL_DATA;
              nextData = cfgReg[7:0];
            end
            default: begin
              nextSel  = SEL_DATA;
              nextData = cfgReg[15:8];
            end
          endcase
        end
      end

      START, DATA: begin
        if (gmii_tx_en) begin
          nextState = DATA;
          if (V_ON_ER != 0 && gmii_tx_er) begin
            nextSel = SEL_V;
          end else begin
            nextSel  = SEL_DATA;
            nextData = gmii_txd;
          end
        end else begin
          nextState = END_T;
          nextSel   = SEL_T;
        end
      end

      END_T: begin
        nextSel   = SEL_R;
        nextState = END_R1;
`ifdef PCS_TX_CARRIER_EXT_EN
        if (extCond) nextState = EXT;
`endif
      end

      END_R1: begin
`ifdef PCS_TX_CARRIER_EXT_EN
        if (extCond) begin
          nextState = EXT;
          nextSel   = SEL_R;
        end else
`endif
        if (tx_even) begin
          nextState = END_R2;
          nextSel   = SEL_R;
        end else begin
          nextState = IDLE;
        end
      end

      END_R2: nextState = IDLE;

`ifdef PCS_TX_CARRIER_EXT_EN
      EXT: begin
        if (extCond) begin
          nextSel = SEL_R;
        end else if (!gmii_tx_en && gmii_tx_er) begin
          nextSel = SEL_V;
        end else if (tx_even) begin
          nextState = END_R2;
          nextSel   = SEL_R;
        end else begin
          nextState = IDLE;
        end
      end
`endif

      default: nextState = IDLE;
    endcase

    nextTx = !(nextState == IDLE || nextState == CFG);
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state        <= IDLE;
      cfgPos       <= 3'd0;
      cfgReg       <= 16'h0000;
      enc_sel      <= SEL_K285;
      enc_data     <= 8'h00;
      enc_rd       <= RD_INIT;
      tx_even      <= 1'b1;
      transmitting <= 1'b0;
    end else begin
      state        <= nextState;
      cfgPos       <= nextCfgPos;
      cfgReg       <= nextCfgReg;
      enc_sel      <= nextSel;
      enc_data     <= nextData;
      enc_rd       <= enc_rd_next;
      tx_even      <= ~tx_even;
      transmitting <= nextTx;
    end
  end

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Table-driven bench for pcs_tx_ordered_set; a toy encoder closes the disparity loop
// (K28.5 and D16.2 flip rd, everything else is neutral).
module tb_pcs_tx_ordered_set;

  localparam logic [3:0] K    = 4'b1100;
  localparam logic [3:0] DAT  = 4'b1101;
  localparam logic [3:0] S    = 4'b1000;
  localparam logic [3:0] T    = 4'b1001;
  localparam logic [3:0] R    = 4'b1011;
  localparam logic [3:0] V    = 4'b1010;
  localparam logic [3:0] D215 = 4'b1110;
  localparam logic [3:0] D22  = 4'b1111;
  localparam logic [3:0] D56  = 4'b0000;
  localparam logic [3:0] D162 = 4'b0001;

  logic        tx_clk = 1'b0;
  logic        tx_rst;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [1:0]  xmit;
  logic [15:0] cfg_word;
  logic        enc_rd_next;
  logic [7:0]  enc_data;
  logic [3:0]  enc_sel;
  logic        enc_rd;
  logic        tx_even;
  logic        transmitting;

  always #5 tx_clk = ~tx_clk;

  always_comb enc_rd_next = enc_rd ^ ((enc_sel == K) || (enc_sel == D162));

  pcs_tx_ordered_set dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er), .xmit(xmit), .cfg_word(cfg_word), .enc_rd_next(enc_rd_next),
    .enc_data(enc_data), .enc_sel(enc_sel), .enc_rd(enc_rd), .tx_even(tx_even),
    .transmitting(transmitting)
  );

  typedef struct {
    logic       en;
    logic       er;
    logic [7:0] txd;
    logic [1:0] xm;
    logic [3:0] sel;
    logic [7:0] dat;
    logic       ev;
    logic       tx;
  } vec_t;

  vec_t vecs[$];
  vec_t extVecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic en, input logic er, input logic [7:0] txd,
                              input logic [1:0] xm, input logic [3:0] sel,
                              input logic [7:0] dat, input logic ev, input logic tx);
    vec_t v;
    v.en = en; v.er = er; v.txd = txd; v.xm = xm;
    v.sel = sel; v.dat = dat; v.ev = ev; v.tx = tx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runRow(input vec_t v, input string tag);
    gmii_tx_en = v.en;
    gmii_tx_er = v.er;
    gmii_txd   = v.txd;
    xmit       = v.xm;
    @(posedge tx_clk);
    #1;
    chk({tag, " sel"}, {12'h0, enc_sel}, {12'h0, v.sel});
    chk({tag, " data"}, {8'h0, enc_data}, {8'h0, v.dat});
    chk({tag, " even"}, {15'h0, tx_even}, {15'h0, v.ev});
    chk({tag, " transmitting"}, {15'h0, transmitting}, {15'h0, v.tx});
  endtask

  initial begin
    // Idle pairs, xmit=11 treated as IDLE
    vecs.push_back(mk(0, 0, 8'h00, 2'd0, D162, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd0, K,    8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd3, D162, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd3, K,    8'h00, 1, 0));
    // Config: /C1/ /C2/ /C1/, DATA requested mid-/C1/
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, D162, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, K,    8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, D215, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, DAT,  8'hA0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, DAT,  8'h01, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, K,    8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, D22,  8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, DAT,  8'hA0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, DAT,  8'h01, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd1, K,    8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, D215, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, DAT,  8'hA0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, DAT,  8'h01, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, K,    8'h00, 1, 0));
    // Frame starting on even-next slot; /R/ lands odd so a single /R/
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, D56,  8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 8'h55, 2'd2, S,    8'h00, 1, 1));
    vecs.push_back(mk(1, 0, 8'h55, 2'd2, DAT,  8'h55, 0, 1));
    vecs.push_back(mk(1, 0, 8'hD5, 2'd2, DAT,  8'hD5, 1, 1));
    vecs.push_back(mk(1, 0, 8'hAA, 2'd2, DAT,  8'hAA, 0, 1));
    vecs.push_back(mk(1, 0, 8'hBB, 2'd2, DAT,  8'hBB, 1, 1));
    vecs.push_back(mk(1, 0, 8'hCC, 2'd2, DAT,  8'hCC, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, T,    8'h00, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, R,    8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, K,    8'h00, 1, 0));
    // tx_en rises on odd-next slot, /V/ mid-frame, /R/ on even -> two /R/, tx_en ignored at end
    vecs.push_back(mk(1, 0, 8'h55, 2'd2, D162, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 8'h55, 2'd2, S,    8'h00, 1, 1));
    vecs.push_back(mk(1, 0, 8'hD5, 2'd2, DAT,  8'hD5, 0, 1));
    vecs.push_back(mk(1, 1, 8'h11, 2'd2, V,    8'h00, 1, 1));
    vecs.push_back(mk(1, 0, 8'h22, 2'd2, DAT,  8'h22, 0, 1));
    vecs.push_back(mk(1, 0, 8'h33, 2'd2, DAT,  8'h33, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, T,    8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 2'd2, R,    8'h00, 1, 1));
    vecs.push_back(mk(1, 0, 8'h00, 2'd2, R,    8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 2'd2, K,    8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 8'h55, 2'd2, D162, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 8'h55, 2'd2, S,    8'h00, 1, 1));
    vecs.push_back(mk(1, 0, 8'h44, 2'd2, DAT,  8'h44, 0, 1));

    // Carrier extension after a short frame
    extVecs.push_back(mk(0, 0, 8'h00, 2'd2, D162, 8'h00, 0, 0));
    extVecs.push_back(mk(1, 0, 8'h55, 2'd2, S,    8'h00, 1, 1));
    extVecs.push_back(mk(1, 0, 8'hAA, 2'd2, DAT,  8'hAA, 0, 1));
    extVecs.push_back(mk(0, 1, 8'h0F, 2'd2, T,    8'h00, 1, 1));
    extVecs.push_back(mk(0, 1, 8'h0F, 2'd2, R,    8'h00, 0, 1));
    extVecs.push_back(mk(0, 1, 8'h0F, 2'd2, R,    8'h00, 1, 1));
    extVecs.push_back(mk(0, 1, 8'h0F, 2'd2, R,    8'h00, 0, 1));
    extVecs.push_back(mk(0, 1, 8'h0F, 2'd2, R,    8'h00, 1, 1));
    extVecs.push_back(mk(0, 0, 8'h00, 2'd2, R,    8'h00, 0, 1));
    extVecs.push_back(mk(0, 0, 8'h00, 2'd2, K,    8'h00, 1, 0));

    tx_rst     = 1'b1;
    gmii_txd   = 8'h00;
    gmii_tx_en = 1'b0;
    gmii_tx_er = 1'b0;
    xmit       = 2'd0;
    cfg_word   = 16'h01A0;
    repeat (2) @(posedge tx_clk);
    #1;
    chk("reset sel", {12'h0, enc_sel}, {12'h0, K});
    chk("reset data", {8'h0, enc_data}, 16'h0000);
    chk("reset rd", {15'h0, enc_rd}, 16'h0000);
    chk("reset even", {15'h0, tx_even}, 16'h0001);
    chk("reset transmitting", {15'h0, transmitting}, 16'h0000);
    tx_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      runRow(vecs[i], $sformatf("row%0d", i));

    // Reset mid-frame aborts immediately without /T/
    tx_rst = 1'b1;
    gmii_tx_en = 1'b1;
    gmii_txd = 8'h66;
    @(posedge tx_clk);
    #1;
    chk("abort sel", {12'h0, enc_sel}, {12'h0, K});
    chk("abort data", {8'h0, enc_data}, 16'h0000);
    chk("abort even", {15'h0, tx_even}, 16'h0001);
    chk("abort transmitting", {15'h0, transmitting}, 16'h0000);
    tx_rst = 1'b0;
    gmii_tx_en = 1'b0;
    @(posedge tx_clk);
    #1;
    chk("post-abort idle sel", {12'h0, enc_sel}, {12'h0, D162});
    @(posedge tx_clk);
    #1;
    chk("post-abort K sel", {12'h0, enc_sel}, {12'h0, K});
    // rd_next is 1 here, so reset must override it back to RD_INIT
    tx_rst = 1'b1;
    @(posedge tx_clk);
    #1;
    chk("rd reinit", {15'h0, enc_rd}, 16'h0000);
    chk("rd reinit even", {15'h0, tx_even}, 16'h0001);
    tx_rst = 1'b0;

`ifdef PCS_TX_CARRIER_EXT_EN
    for (int i = 0; i < extVecs.size(); i++)
      runRow(extVecs[i], $sformatf("ext%0d", i));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
